// File: rtl/irq_tick_gen_pkg.sv
// irq_tick_gen_pkg: shared constants and record types for the irq_tick_gen
// timer block.
//   NCH_DEF/CW_DEF/PW_DEF/ICW_DEF : default parameter values for the top.
//   chan_cfg_t  : one channel's configuration (run enable + period word) at the
//                 default counter width.
//   chan_stat_t : one channel's registered status (pulse, pending, overrun).
package irq_tick_gen_pkg;

  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 32;
  localparam int PW_DEF  = 16;
  localparam int ICW_DEF = 16;

  typedef struct packed {
    logic              en;
    logic [CW_DEF-1:0] period;
  } chan_cfg_t;

  typedef struct packed {
    logic pulse;
    logic pending;
    logic overrun;
  } chan_stat_t;

endpackage

// File: rtl/irq_tick_chan.sv
// irq_tick_chan: one programmable-period timer channel.
//   clk, rst     : clock, asynchronous active-high reset
//   tick         : shared prescaler tick (one cycle wide)
//   en           : run enable; low holds the counter at 0
//   period       : expiry period in ticks; 0 means never expire
//   clear        : write-one-to-clear for pending and overrun
//   oneshot      : (only with IRQ_TICK_GEN_ONESHOT_EN) disarm after first expiry
//   stat         : registered pulse / pending / overrun
//   pending_nxt  : next-state pending, so the top can register irq_any in step
// Optional feature macro: IRQ_TICK_GEN_ONESHOT_EN.
module irq_tick_chan
  import irq_tick_gen_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          en,
  input  logic [CW-1:0] period,
  input  logic          clear,
`ifdef IRQ_TICK_GEN_ONESHOT_EN
  input  logic          oneshot,
`endif
  output chan_stat_t    stat,
  output logic          pending_nxt
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          expire;
  logic          armed;

`ifdef IRQ_TICK_GEN_ONESHOT_EN
  logic armed_q, armed_d;
  assign armed = armed_q;

  // A low enable re-arms; the re-armed channel starts counting once en is high
  // again. While disarmed, oneshot changes are ignored because armed_q only
  // leaves 0 through the en-low path.
  always_comb begin
    armed_d = armed_q;
    if (!en) begin
      armed_d = 1'b1;
    end else if (expire && oneshot) begin
      armed_d = 1'b0;
    end
  end
`else
  assign armed = 1'b1;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (tick && armed) begin
      if (period == '0) begin
        cnt_d = '0;
      end else if (cnt_q >= period - CW'(1)) begin
        // >= so a period shortened below the running count expires at once
        expire = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    pulse_d = expire;
    // Expiry beats a simultaneous clear; overrun only when pending was
    // already set and no clear arrives in the same cycle.
    pend_d  = expire | (pend_q & ~clear);
    ovr_d   = ~clear & (ovr_q | (expire & pend_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef IRQ_TICK_GEN_ONESHOT_EN
      armed_q <= 1'b1;
`endif
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
`ifdef IRQ_TICK_GEN_ONESHOT_EN
      armed_q <= armed_d;
`endif
    end
  end

  assign stat.pulse   = pulse_q;
  assign stat.pending = pend_q;
  assign stat.overrun = ovr_q;
  assign pending_nxt  = pend_d;

endmodule

// File: rtl/irq_tick_gen.sv
// irq_tick_gen: free-running cycle counter plus a shared prescaler driving NCH
// programmable-period interrupt channels.
//   axi_aclk, axi_areset : clock, asynchronous active-high reset
//   en[NCH]              : per-channel run enable
//   period[NCH*CW]       : channel i period in ticks at [i*CW +: CW]
//   prescale[PW]         : a tick occurs every prescale+1 cycles
//   oneshot[NCH]         : (only with IRQ_TICK_GEN_ONESHOT_EN) one-shot mode
//   clear[NCH]           : write-one-to-clear pending/overrun
//   free_count[CW]       : free-running cycle count
//   icount[ICW]          : top ICW bits of free_count
//   irq_pulse/irq_pending/overrun[NCH], irq_any : interrupt status
// Optional feature macro: IRQ_TICK_GEN_ONESHOT_EN.
module irq_tick_gen
  import irq_tick_gen_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF,
  parameter int PW  = PW_DEF,
  parameter int ICW = ICW_DEF
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic [NCH-1:0]    en,
  input  logic [NCH*CW-1:0] period,
  input  logic [PW-1:0]     prescale,
`ifdef IRQ_TICK_GEN_ONESHOT_EN
  input  logic [NCH-1:0]    oneshot,
`endif
  input  logic [NCH-1:0]    clear,
  output logic [CW-1:0]     free_count,
  output logic [ICW-1:0]    icount,
  output logic [NCH-1:0]    irq_pulse,
  output logic [NCH-1:0]    irq_pending,
  output logic [NCH-1:0]    overrun,
  output logic              irq_any
);

  logic [CW-1:0]  free_q, free_d;
  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic           tick;
  logic           any_q, any_d;
  logic [NCH-1:0] pend_nxt;
  chan_stat_t     stat [NCH];

  always_comb begin
    // >= rather than == so lowering prescale below pcnt reloads immediately
    tick   = (pcnt_q >= prescale);
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    free_d = free_q + CW'(1);
    any_d  = |pend_nxt;
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      free_q <= '0;
      pcnt_q <= '0;
      any_q  <= 1'b0;
    end else begin
      free_q <= free_d;
      pcnt_q <= pcnt_d;
      any_q  <= any_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    irq_tick_chan #(.CW(CW)) u_chan (
      .clk         (axi_aclk),
      .rst         (axi_areset),
      .tick        (tick),
      .en          (en[i]),
      .period      (period[i*CW +: CW]),
      .clear       (clear[i]),
`ifdef IRQ_TICK_GEN_ONESHOT_EN
      .oneshot     (oneshot[i]),
`endif
      .stat        (stat[i]),
      .pending_nxt (pend_nxt[i])
    );
    assign irq_pulse[i]   = stat[i].pulse;
    assign irq_pending[i] = stat[i].pending;
    assign overrun[i]     = stat[i].overrun;
  end

  assign free_count = free_q;
  assign icount     = free_q[CW-1 -: ICW];
  assign irq_any    = any_q;

endmodule
